// File: rtl/sensor_alarm_ctrl.sv
// Sensor alarm controller: command decode, persistence-filtered sticky latches, alarm FSM, LED and SSD drive.
// Latency: state updates on the command byte's edge; alarm/leds/SSD follow one cycle later.
// Backpressure: none, one command per dato_valid strobe. LATCH_AUTOCLR_EN enables latch auto-clear.
module sensor_alarm_ctrl #(
    parameter int N_CH      = 4,
    parameter int PERSIST   = 3,
    parameter int SIL_TICKS = 50_000_000,
    parameter int BLINK_DIV = 12_500_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic        CLK_puar,
    input  logic        reset,
    input  logic [7:0]  dato,
    input  logic        dato_valid,
    output logic        alarm,
    output logic [2:0]  leds,
    output logic [10:0] SSD
);
    localparam int CW = $clog2(PERSIST + 1);
    localparam int TW = $clog2(SIL_TICKS + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] PERSIST_C  = CW'(PERSIST);
    localparam logic [TW-1:0] SIL_LOAD   = TW'(SIL_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    // Encoding doubles as the state code shown on digit 3.
    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_ALERT    = 2'd1,
        ST_ALARM    = 2'd2,
        ST_SILENCED = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [N_CH-1:0] raw, raw_nx;
    logic [N_CH-1:0] mask, mask_nx;
    logic [N_CH-1:0] latch, latch_nx;
    logic [CW-1:0]   cnt [N_CH];
    logic [CW-1:0]   cnt_nx [N_CH];
`ifdef LATCH_AUTOCLR_EN
    logic [CW-1:0]   zcnt [N_CH];
    logic [CW-1:0]   zcnt_nx [N_CH];
`endif
    logic [TW-1:0]   sil_timer, sil_nx;
    logic            blink;
    logic [BW-1:0]   blink_cnt;
    logic [SW-1:0]   scan_cnt;
    logic [1:0]      slot;
    logic            is_upd, is_sil, is_clr, is_msk;
    logic            unm_any, new_bit;
    logic [3:0]      lo_idx, pop, digit;
    logic            unused_dato;

    assign unused_dato = ^dato;
    assign is_upd = dato_valid && (dato[7:6] == 2'b00);
    assign is_sil = dato_valid && (dato[7:6] == 2'b01);
    assign is_clr = dato_valid && (dato[7:6] == 2'b10);
    assign is_msk = dato_valid && (dato[7:6] == 2'b11);

    function automatic logic [6:0] seg_font(input logic [3:0] v);
        case (v)
            4'd0:    seg_font = 7'h40;
            4'd1:    seg_font = 7'h79;
            4'd2:    seg_font = 7'h24;
            4'd3:    seg_font = 7'h30;
            4'd4:    seg_font = 7'h19;
            4'd5:    seg_font = 7'h12;
            4'd6:    seg_font = 7'h02;
            4'd7:    seg_font = 7'h78;
            4'd8:    seg_font = 7'h00;
            4'd9:    seg_font = 7'h10;
            default: seg_font = 7'h7F;
        endcase
    endfunction

    always_comb begin
        raw_nx   = raw;
        mask_nx  = mask;
        latch_nx = latch;
        cnt_nx   = cnt;
`ifdef LATCH_AUTOCLR_EN
        zcnt_nx  = zcnt;
`endif
        if (is_upd) begin
            raw_nx = dato[N_CH-1:0];
            for (int i = 0; i < N_CH; i++) begin
                if (raw_nx[i] && !mask[i]) begin
                    if (cnt[i] != PERSIST_C) cnt_nx[i] = cnt[i] + 1'b1;
                end else begin
                    cnt_nx[i] = '0;
                end
                if (cnt_nx[i] == PERSIST_C) latch_nx[i] = 1'b1;
`ifdef LATCH_AUTOCLR_EN
                if (!raw_nx[i]) begin
                    if (zcnt[i] != PERSIST_C) zcnt_nx[i] = zcnt[i] + 1'b1;
                end else begin
                    zcnt_nx[i] = '0;
                end
                if (zcnt_nx[i] == PERSIST_C) latch_nx[i] = 1'b0;
`endif
            end
        end
        if (is_clr) latch_nx = latch & raw;
        if (is_msk) mask_nx = dato[N_CH-1:0];
    end

    // Transitions look at post-update raw/mask/latch so a byte acts in its own cycle.
    always_comb begin
        state_nx = state;
        sil_nx   = sil_timer;
        unm_any  = |(raw_nx & ~mask_nx);
        new_bit  = |(latch_nx & ~latch);
        case (state)
            ST_NORMAL: begin
                if (|latch_nx)   state_nx = ST_ALARM;
                else if (unm_any) state_nx = ST_ALERT;
            end
            ST_ALERT: begin
                if (|latch_nx)    state_nx = ST_ALARM;
                else if (!unm_any) state_nx = ST_NORMAL;
            end
            ST_ALARM: begin
                if (!(|latch_nx)) begin
                    state_nx = ST_NORMAL;
                end else if (is_sil) begin
                    state_nx = ST_SILENCED;
                    sil_nx   = SIL_LOAD;
                end
            end
            ST_SILENCED: begin
                if (!(|latch_nx))           state_nx = ST_NORMAL;
                else if (new_bit)           state_nx = ST_ALARM;
                else if (is_sil)            sil_nx   = SIL_LOAD;
                else if (sil_timer == '0)   state_nx = ST_ALARM;
                else                        sil_nx   = sil_timer - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_puar) begin
        if (reset) begin
            state     <= ST_NORMAL;
            raw       <= '0;
            mask      <= '0;
            latch     <= '0;
            sil_timer <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
`ifdef LATCH_AUTOCLR_EN
                zcnt[i] <= '0;
`endif
            end
        end else begin
            state     <= state_nx;
            raw       <= raw_nx;
            mask      <= mask_nx;
            latch     <= latch_nx;
            sil_timer <= sil_nx;
            cnt       <= cnt_nx;
`ifdef LATCH_AUTOCLR_EN
            zcnt      <= zcnt_nx;
`endif
        end
    end

    // Blink phase restarts high on every ALARM entry, including re-sound after silence.
    always_ff @(posedge CLK_puar) begin
        if (reset) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
            scan_cnt  <= '0;
            slot      <= 2'd0;
        end else begin
            if (state_nx == ST_ALARM && state != ST_ALARM) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (state == ST_ALARM) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink     <= ~blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        lo_idx = 4'hF;
        pop    = 4'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (latch[i]) lo_idx = 4'(i);
        end
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + {3'b000, latch[i]};
        end
        case (slot)
            2'd0:    digit = lo_idx;
            2'd1:    digit = pop;
            2'd2:    digit = 4'hF;
            default: digit = {2'b00, state};
        endcase
    end

    always_ff @(posedge CLK_puar) begin
        if (reset) begin
            alarm <= 1'b0;
            leds  <= 3'b001;
            SSD   <= 11'b1110_1111111;
        end else begin
            alarm <= (state == ST_ALARM);
            case (state)
                ST_NORMAL:   leds <= 3'b001;
                ST_ALERT:    leds <= 3'b010;
                ST_ALARM:    leds <= {blink, 2'b00};
                default:     leds <= 3'b100;
            endcase
            SSD <= {~(4'b0001 << slot), seg_font(digit)};
        end
    end
endmodule
